// File: rtl/tape_rim_punch.sv
// RIM tape punch: walks a PDP-1 core address range and emits the DIO/JMP
// character stream the RIM loader consumes, with 0x00 leader and trailer.
module tape_rim_punch #(
  parameter int LEADER_LEN  = 16,
  parameter int TRAILER_LEN = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] first_address,
  input  logic [11:0] last_address,
  input  logic [11:0] jump_address,
  input  logic        abort,
  output logic [11:0] mem_address,
  output logic        mem_rd,
  input  logic [17:0] mem_rd_data,
  output logic [7:0]  tape_char,
  output logic        tape_valid,
  input  logic        tape_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] LEADER_LAST  = 16'(LEADER_LEN - 1);
  localparam logic [15:0] TRAILER_LAST = 16'(TRAILER_LEN - 1);
  localparam logic [15:0] WAIT_LAST    = 16'(MEM_LATENCY - 1);

  localparam logic [7:0] DIO_CHAR = 8'h9A;
  localparam logic [7:0] JMP_CHAR = 8'hB0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEADER,
    S_FETCH,
    S_WAIT,
    S_CMD,
    S_AH,
    S_AL,
    S_D1,
    S_D2,
    S_D3,
    S_NEXT,
    S_JCMD,
    S_JAH,
    S_JAL,
    S_TRAILER,
    S_DONE
  } state_t;

  state_t      state_reg, state_next;
  logic [11:0] cur_reg, cur_next;
  logic [11:0] last_reg, last_next;
  logic [11:0] jump_reg, jump_next;
  logic [17:0] word_reg, word_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [7:0]  char_reg, char_next;
  logic        valid_reg, valid_next;
  logic        xfer;

  assign xfer = valid_reg && tape_ready;

  always_comb begin
    state_next = state_reg;
    cur_next   = cur_reg;
    last_next  = last_reg;
    jump_next  = jump_reg;
    word_next  = word_reg;
    cnt_next   = cnt_reg;

    case (state_reg)
      S_IDLE: begin
        if (start && !abort) begin
          cur_next  = first_address;
          last_next = last_address;
          jump_next = jump_address;
          cnt_next  = '0;
          if (LEADER_LEN > 0)
            state_next = S_LEADER;
          else if (last_address < first_address)
            state_next = S_JCMD;
          else
            state_next = S_FETCH;
        end
      end
      S_LEADER: begin
        if (xfer) begin
          if (cnt_reg == LEADER_LAST) begin
            cnt_next   = '0;
            // cur still holds the first address here; an empty range skips straight to JMP
            state_next = (last_reg < cur_reg) ? S_JCMD : S_FETCH;
          end else begin
            cnt_next = cnt_reg + 16'd1;
          end
        end
      end
      S_FETCH: begin
        cnt_next   = '0;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_reg == WAIT_LAST) begin
          word_next  = mem_rd_data;
          cnt_next   = '0;
          state_next = S_CMD;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      S_CMD:  if (xfer) state_next = S_AH;
      S_AH:   if (xfer) state_next = S_AL;
      S_AL:   if (xfer) state_next = S_D1;
      S_D1:   if (xfer) state_next = S_D2;
      S_D2:   if (xfer) state_next = S_D3;
      S_D3:   if (xfer) state_next = S_NEXT;
      S_NEXT: begin
        // Compare before incrementing so a range ending at 0xFFF never wraps.
        if (cur_reg == last_reg) begin
          state_next = S_JCMD;
        end else begin
          cur_next   = cur_reg + 12'd1;
          state_next = S_FETCH;
        end
      end
      S_JCMD: if (xfer) state_next = S_JAH;
      S_JAH:  if (xfer) state_next = S_JAL;
      S_JAL: begin
        if (xfer) begin
          cnt_next   = '0;
          state_next = (TRAILER_LEN > 0) ? S_TRAILER : S_DONE;
        end
      end
      S_TRAILER: begin
        if (xfer) begin
          if (cnt_reg == TRAILER_LAST)
            state_next = S_DONE;
          else
            cnt_next = cnt_reg + 16'd1;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    if (abort && state_reg != S_IDLE) begin
      state_next = S_IDLE;
      cnt_next   = '0;
    end

    // Character register is loaded for the state being entered, so it is
    // stable for as long as that state waits on tape_ready.
    char_next  = 8'h00;
    valid_next = 1'b1;
    case (state_next)
      S_LEADER:  char_next = 8'h00;
      S_TRAILER: char_next = 8'h00;
      S_CMD:     char_next = DIO_CHAR;
      S_AH:      char_next = {2'b10, cur_next[11:6]};
      S_AL:      char_next = {2'b10, cur_next[5:0]};
      S_D1:      char_next = {2'b10, word_next[17:12]};
      S_D2:      char_next = {2'b10, word_next[11:6]};
      S_D3:      char_next = {2'b10, word_next[5:0]};
      S_JCMD:    char_next = JMP_CHAR;
      S_JAH:     char_next = {2'b10, jump_next[11:6]};
      S_JAL:     char_next = {2'b10, jump_next[5:0]};
      default:   valid_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      cur_reg   <= '0;
      last_reg  <= '0;
      jump_reg  <= '0;
      word_reg  <= '0;
      cnt_reg   <= '0;
      char_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cur_reg   <= cur_next;
      last_reg  <= last_next;
      jump_reg  <= jump_next;
      word_reg  <= word_next;
      cnt_reg   <= cnt_next;
      char_reg  <= char_next;
      valid_reg <= valid_next;
    end
  end

  assign mem_address = cur_reg;
  assign mem_rd      = (state_reg == S_FETCH);
  assign tape_char   = char_reg;
  assign tape_valid  = valid_reg;
  assign busy        = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign done        = (state_reg == S_DONE);

endmodule

// File: tb/tb_tape_rim_punch.sv
// Bench for tape_rim_punch: random core contents and backpressure, checked
// against a byte-stream model built from the RIM block format.
module tb_tape_rim_punch;
  localparam int LL  = 2;
  localparam int TL  = 2;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        tape_ready = 1'b1;
  logic [11:0] first_address = '0;
  logic [11:0] last_address = '0;
  logic [11:0] jump_address = '0;
  logic [11:0] mem_address;
  logic        mem_rd;
  logic [17:0] mem_rd_data;
  logic [7:0]  tape_char;
  logic        tape_valid;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  tape_rim_punch #(.LEADER_LEN(LL), .TRAILER_LEN(TL), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .start(start),
    .first_address(first_address), .last_address(last_address),
    .jump_address(jump_address), .abort(abort),
    .mem_address(mem_address), .mem_rd(mem_rd), .mem_rd_data(mem_rd_data),
    .tape_char(tape_char), .tape_valid(tape_valid), .tape_ready(tape_ready),
    .busy(busy), .done(done)
  );

  // Core memory with LAT-cycle read latency; data outside the valid slot is junk.
  logic [17:0] mem [0:4095];
  logic [17:0] pipe_data [LAT];
  logic        pipe_vld  [LAT];
  always @(posedge clk) begin
    pipe_data[0] <= mem[mem_address];
    pipe_vld[0]  <= mem_rd;
    for (int i = 1; i < LAT; i++) begin
      pipe_data[i] <= pipe_data[i-1];
      pipe_vld[i]  <= pipe_vld[i-1];
    end
  end
  assign mem_rd_data = pipe_vld[LAT-1] ? pipe_data[LAT-1] : 18'h2A5A5;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: collect transferred characters, read addresses, done pulses; check holds.
  logic [7:0]  got_q[$];
  logic [11:0] rd_q[$];
  logic [7:0]  exp_q[$];
  logic [11:0] exp_rd[$];
  int          done_cnt = 0;
  logic        prev_stall = 1'b0;
  logic        prev_abort = 1'b0;
  logic [7:0]  prev_char = '0;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !prev_abort) begin
        check_eq("hold_valid", tape_valid, 1);
        check_eq("hold_char", tape_char, prev_char);
      end
      if (tape_valid && tape_ready) got_q.push_back(tape_char);
      if (mem_rd) rd_q.push_back(mem_address);
      if (done) done_cnt++;
      prev_stall = tape_valid && !tape_ready;
      prev_char  = tape_char;
      prev_abort = abort;
    end
  end

  int ready_mode = 0;  // 0: always ready, 1: random, 2: driven by the main sequence
  initial forever begin
    @(posedge clk); #1;
    if (ready_mode == 0) tape_ready = 1'b1;
    else if (ready_mode == 1) tape_ready = 1'($urandom_range(0, 1));
  end

  // Reference stream: leader, one 6-char DIO block per word, JMP block, trailer.
  task automatic build_exp(input logic [11:0] f, input logic [11:0] l, input logic [11:0] j);
    int w;
    exp_q.delete();
    exp_rd.delete();
    repeat (LL) exp_q.push_back(8'h00);
    for (int a = int'(f); a <= int'(l); a++) begin
      w = int'(mem[a]);
      exp_rd.push_back(12'(a));
      exp_q.push_back(8'h9A);
      exp_q.push_back(8'(128 + (a / 64) % 64));
      exp_q.push_back(8'(128 + a % 64));
      exp_q.push_back(8'(128 + (w / 4096) % 64));
      exp_q.push_back(8'(128 + (w / 64) % 64));
      exp_q.push_back(8'(128 + w % 64));
    end
    exp_q.push_back(8'hB0);
    exp_q.push_back(8'(128 + (int'(j) / 64) % 64));
    exp_q.push_back(8'(128 + int'(j) % 64));
    repeat (TL) exp_q.push_back(8'h00);
  endtask

  task automatic pulse_start(input logic [11:0] f, input logic [11:0] l, input logic [11:0] j);
    @(posedge clk); #1;
    first_address = f; last_address = l; jump_address = j; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_punch(input string name, input logic [11:0] f, input logic [11:0] l,
                           input logic [11:0] j, input int mode);
    int k;
    build_exp(f, l, j);
    got_q.delete(); rd_q.delete(); done_cnt = 0; ready_mode = mode;
    pulse_start(f, l, j);
    check_eq({name, "_busy"}, busy, 1);
    // A start while busy, with different addresses, must change nothing.
    first_address = 12'($urandom); last_address = 12'($urandom); jump_address = 12'($urandom);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (done) break;
    end
    check_eq({name, "_done_seen"}, k < 5000, 1);
    check_eq({name, "_busy_at_done"}, busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq({name, "_done_count"}, done_cnt, 1);
    check_eq({name, "_idle_valid"}, tape_valid, 0);
    check_eq({name, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check_eq($sformatf("%s_byte%0d", name, i), got_q[i], exp_q[i]);
      if (got_q[i] !== exp_q[i]) break;
    end
    check_eq({name, "_reads"}, rd_q.size(), exp_rd.size());
    for (int i = 0; i < rd_q.size() && i < exp_rd.size(); i++)
      check_eq($sformatf("%s_rdaddr%0d", name, i), rd_q[i], exp_rd[i]);
    $display("run %s first=%03h last=%03h jump=%03h chars=%0d reads=%0d", name, f, l, j,
             got_q.size(), rd_q.size());
  endtask

  logic [7:0] lit [13];
  logic [11:0] rf, rl;

  initial begin
    int k;
    for (int i = 0; i < 4096; i++) mem[i] = 18'($urandom);
    mem[12'h010] = 18'o123456;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", tape_valid, 0);
    check_eq("rst_char", tape_char, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_mem_rd", mem_rd, 0);
    reset = 1'b0;

    // Literal stream for a single-word punch.
    run_punch("single", 12'h010, 12'h010, 12'h004, 0);
    lit = '{8'h00, 8'h00, 8'h9A, 8'h80, 8'h90, 8'h8A, 8'h9C, 8'hAE, 8'hB0, 8'h80, 8'h84,
            8'h00, 8'h00};
    for (int i = 0; i < 13 && i < got_q.size(); i++)
      check_eq($sformatf("single_lit%0d", i), got_q[i], lit[i]);

    run_punch("range3", 12'h100, 12'h102, 12'h100, 0);
    run_punch("range3_bp", 12'h100, 12'h102, 12'h100, 1);
    run_punch("top_word", 12'hFFF, 12'hFFF, 12'h123, 1);
    run_punch("empty", 12'h020, 12'h01F, 12'h055, 0);
    for (int r = 0; r < 6; r++) begin
      rf = 12'($urandom);
      rl = (int'(rf) + 4 > 4095) ? 12'hFFF : rf + 12'($urandom_range(0, 4));
      run_punch($sformatf("rand%0d", r), rf, rl, 12'($urandom), 1);
    end

    // start and abort together while idle: nothing starts.
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check_eq("start_abort_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("start_abort_valid", tape_valid, 0);

    // Abort while holding D2 of the second word.
    build_exp(12'h200, 12'h202, 12'h200);
    got_q.delete(); rd_q.delete(); done_cnt = 0;
    ready_mode = 2; tape_ready = 1'b1;
    pulse_start(12'h200, 12'h202, 12'h200);
    for (k = 0; k < 500; k++) begin
      @(posedge clk); #1;
      if (got_q.size() == 12) break;
    end
    tape_ready = 1'b0;
    check_eq("abort_reach_d2", k < 500, 1);
    check_eq("abort_d2_valid", tape_valid, 1);
    check_eq("abort_d2_char", tape_char, exp_q[12]);
    @(posedge clk); #1;
    start = 1'b1; first_address = 12'h300; last_address = 12'h300;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_valid", tape_valid, 0);
    tape_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_eq("abort_no_done", done_cnt, 0);
    check_eq("abort_chars", got_q.size(), 12);
    check_eq("abort_reads", rd_q.size(), 2);
    check_eq("abort_still_idle", busy, 0);
    $display("run abort first=200 last=202 chars=%0d reads=%0d", got_q.size(), rd_q.size());
    run_punch("after_abort", 12'h3F0, 12'h3F1, 12'h3F0, 0);

    // Asynchronous reset in the middle of a punch.
    got_q.delete(); done_cnt = 0; ready_mode = 0;
    pulse_start(12'h100, 12'h102, 12'h100);
    repeat (10) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check_eq("arst_valid", tape_valid, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_mem_rd", mem_rd, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("arst_no_done", done_cnt, 0);
    check_eq("arst_idle", busy, 0);
    $display("run reset_mid chars_before_reset=%0d", got_q.size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
